// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the five-stage pipe: stage-register enables, flushes
// and bubbles, load-use/branch resolution, debug halt/drain/step and stall counting.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             halt_req,
  input  logic             resume_req,
  input  logic             step_req,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT, STEP} state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] drain_cnt, drain_nxt;
  logic       hazard;
  logic       stall_inc;

  assign hazard = ex_memread && (ex_wreg != 5'd0) &&
                  ((ex_wreg == id_rs1) || (id_uses_rs2 && (ex_wreg == id_rs2)));

  // Stage-register controls; everything reads as 0 while reset is held low.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_we     = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b0;
    halted      = 1'b0;
    if (reset) begin
      unique case (state)
        RUN, STEP: begin
          if (mem_busy) begin
            pc_we = 1'b0;
          end else if (ex_branch_taken) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_we     = 1'b1;
            idex_bubble = 1'b1;
            exmem_we    = 1'b1;
          end else if (hazard) begin
            idex_we     = 1'b1;
            idex_bubble = 1'b1;
            exmem_we    = 1'b1;
          end else begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            idex_we  = 1'b1;
            exmem_we = 1'b1;
          end
        end
        DRAIN: begin
          // Fetch is suppressed, so NOPs follow the in-flight instructions out.
          if (!mem_busy) begin
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            idex_we    = 1'b1;
            exmem_we   = 1'b1;
          end
        end
        HALT: halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    unique case (state)
      RUN: begin
        if (halt_req) begin
          state_nxt = DRAIN;
          drain_nxt = DRAIN_INIT;
        end
      end
      DRAIN: begin
        if (!mem_busy) begin
          if (drain_cnt <= 4'd1) begin
            state_nxt = HALT;
            drain_nxt = 4'd0;
          end else begin
            drain_nxt = drain_cnt - 4'd1;
          end
        end
      end
      HALT: begin
        if (resume_req)    state_nxt = RUN;
        else if (step_req) state_nxt = STEP;
      end
      STEP: begin
        if (!mem_busy) state_nxt = HALT;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      drain_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  assign stall_inc = ((state == RUN) || (state == STEP)) && !pc_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table in RUN plus hand-written
// halt/drain/step/reset sequences; a narrow second instance covers saturation.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_wreg;
  logic        id_uses_rs2, ex_memread, ex_branch_taken, mem_busy;
  logic        halt_req, resume_req, step_req, cnt_clr;
  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, halted;
  logic [15:0] stall_cnt;
  logic        pc_we2, ifid_we2, ifid_flush2, idex_we2, idex_bubble2, exmem_we2, halted2;
  logic [2:0]  stall_cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt;

  localparam logic [5:0] C_RUN   = 6'b110101;
  localparam logic [5:0] C_HAZ   = 6'b000111;
  localparam logic [5:0] C_BR    = 6'b111111;
  localparam logic [5:0] C_DRAIN = 6'b011101;
  localparam logic [5:0] C_OFF   = 6'b000000;

  wire [5:0] ctl = {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_wreg(ex_wreg), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
    .cnt_clr(cnt_clr), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_we(idex_we), .idex_bubble(idex_bubble), .exmem_we(exmem_we), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.DRAIN_CYCLES(1), .CNT_W(3)) dut2 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_wreg(ex_wreg), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
    .cnt_clr(cnt_clr), .pc_we(pc_we2), .ifid_we(ifid_we2), .ifid_flush(ifid_flush2),
    .idex_we(idex_we2), .idex_bubble(idex_bubble2), .exmem_we(exmem_we2), .halted(halted2),
    .stall_cnt(stall_cnt2)
  );

  typedef struct {
    logic [4:0] rs1, rs2, wreg;
    logic       uses, mr, br, busy;
    logic [5:0] exp_ctl;
    int         inc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic setin(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses,
                       input logic [4:0] wreg, input logic mr, input logic br, input logic busy);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = uses; ex_wreg = wreg;
    ex_memread = mr; ex_branch_taken = br; mem_busy = busy;
  endtask

  task automatic idle();
    setin(5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 0};
    vecs[1] = '{5'd5, 5'd2, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, C_HAZ, 1};
    vecs[2] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, C_RUN, 0};
    vecs[3] = '{5'd1, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, C_RUN, 0};
    vecs[4] = '{5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, C_HAZ, 1};
    vecs[5] = '{5'd5, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, C_BR,  0};
    vecs[6] = '{5'd5, 5'd2, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, C_OFF, 1};
    vecs[7] = '{5'd5, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 0};
    vecs[8] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, C_OFF, 1};

    reset = 1'b1;
    halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0; cnt_clr = 1'b0;
    idle();
    #1 reset = 1'b0;
    nxt(); nxt();
    #4;
    chk("rst_ctl", 32'(ctl), 32'(C_OFF));
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_cnt2", 32'(stall_cnt2), 32'd0);
    nxt();
    reset = 1'b1;
    #4 chk("run_after_rst", 32'(ctl), 32'(C_RUN));
    nxt();

    exp_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      setin(vecs[i].rs1, vecs[i].rs2, vecs[i].uses, vecs[i].wreg,
            vecs[i].mr, vecs[i].br, vecs[i].busy);
      #4 chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].exp_ctl));
      nxt();
      exp_cnt += vecs[i].inc;
      chk($sformatf("vec%0d_cnt", i), 32'(stall_cnt), 32'(exp_cnt));
    end

    // Clear beats a simultaneous stall; narrow counter saturates and holds.
    setin(5'd5, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cnt_clr = 1'b1;
    nxt();
    cnt_clr = 1'b0;
    chk("clr_cnt", 32'(stall_cnt), 32'd0);
    chk("clr_cnt2", 32'(stall_cnt2), 32'd0);
    for (int i = 0; i < 9; i++) nxt();
    chk("stall9_cnt", 32'(stall_cnt), 32'd9);
    chk("sat_cnt2", 32'(stall_cnt2), 32'd7);
    nxt();
    chk("sat_hold_cnt2", 32'(stall_cnt2), 32'd7);
    exp_cnt = 10;
    chk("stall10_cnt", 32'(stall_cnt), 32'(exp_cnt));
    idle();

    // Halt: DRAIN for cycles 1..3, halted from cycle 4; narrow instance halts at 2.
    halt_req = 1'b1;
    #4 chk("halt_req_cycle_ctl", 32'(ctl), 32'(C_RUN));
    nxt();
    halt_req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #4;
      chk($sformatf("drain_c%0d_halted", c), 32'(halted), 32'(c >= 4));
      chk($sformatf("drain_c%0d_ctl", c), 32'(ctl), 32'((c < 4) ? C_DRAIN : C_OFF));
      chk($sformatf("drain1_c%0d_halted2", c), 32'(halted2), 32'(c >= 2));
      nxt();
    end
    chk("drain_cnt_unchanged", 32'(stall_cnt), 32'(exp_cnt));

    resume_req = 1'b1;
    #4 chk("resume_cycle_halted", 32'(halted), 32'd1);
    nxt();
    resume_req = 1'b0;
    #4;
    chk("resumed_halted", 32'(halted), 32'd0);
    chk("resumed_ctl", 32'(ctl), 32'(C_RUN));
    nxt();

    // Halt with a mem_busy pulse in cycle 2 pushes halted out by one cycle.
    halt_req = 1'b1;
    nxt();
    halt_req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      mem_busy = (c == 2);
      #4;
      chk($sformatf("drainbusy_c%0d_halted", c), 32'(halted), 32'(c >= 5));
      chk($sformatf("drainbusy_c%0d_ctl", c), 32'(ctl),
          32'((c == 2 || c == 5) ? C_OFF : C_DRAIN));
      nxt();
    end
    mem_busy = 1'b0;
    chk("drainbusy_cnt", 32'(stall_cnt), 32'(exp_cnt));

    // Single step with a load-use hazard: RUN rules for one cycle, counted stall.
    step_req = 1'b1;
    #4 chk("step_req_ctl", 32'(ctl), 32'(C_OFF));
    nxt();
    step_req = 1'b0;
    setin(5'd5, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    #4;
    chk("step_halted", 32'(halted), 32'd0);
    chk("step_ctl", 32'(ctl), 32'(C_HAZ));
    nxt();
    exp_cnt++;
    chk("step_cnt", 32'(stall_cnt), 32'(exp_cnt));
    idle();
    #4;
    chk("after_step_halted", 32'(halted), 32'd1);
    chk("after_step_ctl", 32'(ctl), 32'(C_OFF));
    nxt();

    // Step held by mem_busy, then completes.
    step_req = 1'b1;
    nxt();
    step_req = 1'b0;
    mem_busy = 1'b1;
    #4;
    chk("stepbusy_halted", 32'(halted), 32'd0);
    chk("stepbusy_ctl", 32'(ctl), 32'(C_OFF));
    nxt();
    mem_busy = 1'b0;
    exp_cnt++;
    #4;
    chk("stepbusy2_halted", 32'(halted), 32'd0);
    chk("stepbusy2_ctl", 32'(ctl), 32'(C_RUN));
    nxt();
    #4;
    chk("stepbusy_done_halted", 32'(halted), 32'd1);
    chk("stepbusy_cnt", 32'(stall_cnt), 32'(exp_cnt));
    nxt();

    // resume_req wins over step_req.
    step_req = 1'b1; resume_req = 1'b1;
    nxt();
    step_req = 1'b0; resume_req = 1'b0;
    #4 chk("both_halted", 32'(halted), 32'd0);
    nxt();
    #4;
    chk("both_still_run", 32'(halted), 32'd0);
    chk("both_ctl", 32'(ctl), 32'(C_RUN));
    nxt();

    // Async reset while in STEP.
    halt_req = 1'b1;
    nxt();
    halt_req = 1'b0;
    nxt(); nxt(); nxt();
    #4 chk("rehalt_halted", 32'(halted), 32'd1);
    nxt();
    step_req = 1'b1;
    nxt();
    step_req = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_step_ctl", 32'(ctl), 32'(C_OFF));
    chk("rst_step_halted", 32'(halted), 32'd0);
    chk("rst_step_cnt", 32'(stall_cnt), 32'd0);
    nxt();
    reset = 1'b1;
    #4 chk("post_rst_ctl", 32'(ctl), 32'(C_RUN));
    nxt();
    #4;
    chk("post_rst_run_halted", 32'(halted), 32'd0);
    chk("post_rst_run_ctl", 32'(ctl), 32'(C_RUN));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
